// File: rtl/qacc_sat_relu.sv
// qacc_sat_relu
//
// Streaming fixed-point window accumulator. It sums LEN signed Q-format terms
// in a guard-bit-widened register, saturates the total back to N bits,
// optionally rectifies it (ReLU), and hands one activation per window to a
// valid/ready consumer.
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   synchronous, active-low reset
//   in_valid   in   1   in_data holds a valid term
//   in_ready   out  1   a term can be accepted this cycle (only while summing)
//   in_data    in   N   signed Q-format term
//   out_valid  out  1   out_data/out_sat hold a finished window result
//   out_ready  in   1   consumer accepts the result this cycle
//   out_data   out  N   saturated (and, if RELU, rectified) window sum
//   out_sat    out  1   window sum fell outside the N-bit signed range
//
// out_data/out_sat keep their last values between results; only out_valid
// qualifies them.

module qacc_sat_relu #(
    parameter int N    = 8,
    parameter int Q    = 4,
    parameter int LEN  = 9,
    parameter bit RELU = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_sat
);

    // LEN terms of at most 2^(N-1) magnitude need clog2(LEN) guard bits, so
    // the accumulator can never wrap.
    localparam int CNT_W = $clog2(LEN);
    localparam int ACC_W = N + CNT_W;

    localparam logic signed [ACC_W-1:0] SUM_MAX = {{(CNT_W + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN = {{(CNT_W + 1){1'b1}}, {(N - 1){1'b0}}};
    localparam logic [N-1:0]            OUT_MAX = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0]            OUT_MIN = {1'b1, {(N - 1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(LEN - 1);

    // Q only documents the binary point (addition preserves it); it is
    // still range-checked here together with LEN.
    generate
        if (LEN < 2 || Q < 0 || Q >= N) begin : g_bad_params
            $error("qacc_sat_relu: parameters require LEN >= 2 and 0 <= Q < N");
        end
    endgenerate

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N-1:0]             data_q, data_d;
    logic                     sat_q, sat_d;

    logic                     accept;
    logic                     last_term;
    logic signed [ACC_W-1:0]  term_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [N-1:0]             sat_val;
    logic                     sum_sat;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave ACC on the final term of a window, leave OUT on
    // the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC: if (accept && last_term) state_d = S_OUT;
            S_OUT: if (out_ready)           state_d = S_ACC;
            default:                        state_d = S_ACC;
        endcase
    end

    // FSM outputs: the block either collects terms or offers a result,
    // never both.
    always_comb begin
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_OUT);
    end

    assign accept    = in_valid && in_ready;
    assign last_term = (cnt_q == CNT_LAST);
    assign term_ext  = {{CNT_W{in_data[N-1]}}, in_data};
    assign sum       = acc_q + term_ext;

    // Clamp the wide window sum to N bits, then rectify. Saturation is
    // flagged even when ReLU later zeroes a negative clamp.
    always_comb begin
        sat_val = sum[N-1:0];
        sum_sat = 1'b0;
        if (sum > SUM_MAX) begin
            sat_val = OUT_MAX;
            sum_sat = 1'b1;
        end else if (sum < SUM_MIN) begin
            sat_val = OUT_MIN;
            sum_sat = 1'b1;
        end
        if (RELU && sat_val[N-1]) begin
            sat_val = '0;
        end
    end

    // Datapath next state: accumulate accepted terms; on the last one clear
    // the window and capture the finished result, which then holds until
    // the next window completes.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        sat_d  = sat_q;
        if (accept) begin
            if (last_term) begin
                acc_d  = '0;
                cnt_d  = '0;
                data_d = sat_val;
                sat_d  = sum_sat;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers; reset discards any partial window, including a
    // term presented on the reset edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    assign out_data = data_q;
    assign out_sat  = sat_q;

endmodule

// File: tb/tb_qacc_sat_relu.sv
// Testbench for qacc_sat_relu. Two instances share every input: one with
// ReLU enabled and one passing signed results. A queue-based model of the
// window sum predicts both every cycle; directed windows add literal
// expectations for known sums.

module tb_qacc_sat_relu;

    localparam int N   = 8;
    localparam int Q   = 4;
    localparam int LEN = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic [N-1:0] inData;
    logic         outReady;

    logic         inReadyRelu, outValidRelu, outSatRelu;
    logic [N-1:0] outDataRelu;
    logic         inReadyLin, outValidLin, outSatLin;
    logic [N-1:0] outDataLin;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    qacc_sat_relu #(.N(N), .Q(Q), .LEN(LEN), .RELU(1'b1)) uRelu (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReadyRelu),
        .in_data   (inData),
        .out_valid (outValidRelu),
        .out_ready (outReady),
        .out_data  (outDataRelu),
        .out_sat   (outSatRelu)
    );

    qacc_sat_relu #(.N(N), .Q(Q), .LEN(LEN), .RELU(1'b0)) uLin (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReadyLin),
        .in_data   (inData),
        .out_valid (outValidLin),
        .out_ready (outReady),
        .out_data  (outDataLin),
        .out_sat   (outSatLin)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: the terms of the current window live in a queue; when
    // LEN have been collected their plain integer sum is clamped and
    // rectified, and a result is pending until the consumer takes it.
    int           windowQ[$];
    bit           modelReady = 1'b0;
    bit           pending    = 1'b0;
    logic [N-1:0] expDataRelu = '0;
    logic [N-1:0] expDataLin  = '0;
    bit           expSat      = 1'b0;

    always @(posedge clk) begin
        int total;
        int clamped;
        if (!rst_n) begin
            windowQ.delete();
            pending     = 1'b0;
            expDataRelu = '0;
            expDataLin  = '0;
            expSat      = 1'b0;
            modelReady  = 1'b1;
        end else if (pending) begin
            if (outReady) pending = 1'b0;
        end else if (inValid) begin
            windowQ.push_back(int'($signed(inData)));
            if (windowQ.size() == LEN) begin
                total = 0;
                foreach (windowQ[i]) total += windowQ[i];
                clamped = total;
                expSat  = 1'b0;
                if (total > (1 << (N - 1)) - 1) begin
                    clamped = (1 << (N - 1)) - 1;
                    expSat  = 1'b1;
                end else if (total < -(1 << (N - 1))) begin
                    clamped = -(1 << (N - 1));
                    expSat  = 1'b1;
                end
                expDataLin  = N'(clamped);
                expDataRelu = (clamped < 0) ? '0 : N'(clamped);
                pending     = 1'b1;
                windowQ.delete();
            end
        end
    end

    // Every cycle, both instances are compared against the model.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("relu in_ready",  inReadyRelu,  !pending);
            checkOutput("relu out_valid", outValidRelu, pending);
            checkOutput("relu out_data",  outDataRelu,  expDataRelu);
            checkOutput("relu out_sat",   outSatRelu,   expSat);
            checkOutput("lin in_ready",   inReadyLin,   !pending);
            checkOutput("lin out_valid",  outValidLin,  pending);
            checkOutput("lin out_data",   outDataLin,   expDataLin);
            checkOutput("lin out_sat",    outSatLin,    expSat);
        end
    end

    // Counts rising edges of out_valid for the reset-mid-window scenario.
    int   pulseCount = 0;
    logic prevValid  = 1'b0;
    always @(negedge clk) begin
        if (outValidRelu === 1'b1 && prevValid !== 1'b1) pulseCount++;
        prevValid = outValidRelu;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents one term after 'gap' idle cycles and returns just after the
    // edge on which it was accepted.
    task automatic applyStimulus(input logic [N-1:0] term, input int gap);
        int waitCycles;
        inValid = 1'b0;
        repeat (gap) tick();
        inValid = 1'b1;
        inData  = term;
        waitCycles = 0;
        while (inReadyRelu !== 1'b1 && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        if (waitCycles >= 50) checkOutput("accept timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic sendWindow(input logic [N-1:0] term, input int maxGap);
        for (int i = 0; i < LEN; i++) applyStimulus(term, $urandom_range(0, maxGap));
    endtask

    // Called right after the last term of a window is accepted: the result
    // must already be valid. Optionally stalls the consumer while toggling
    // in_valid, then completes the handshake.
    task automatic awaitResult(input string name, input logic [N-1:0] eRelu,
                               input logic [N-1:0] eLin, input logic eSat,
                               input int stall);
        inValid = 1'b0;
        checkOutput({name, " latency"},   outValidRelu, 32'd1);
        checkOutput({name, " relu data"}, outDataRelu,  eRelu);
        checkOutput({name, " lin data"},  outDataLin,   eLin);
        checkOutput({name, " relu sat"},  outSatRelu,   eSat);
        checkOutput({name, " lin sat"},   outSatLin,    eSat);
        for (int i = 0; i < stall; i++) begin
            inValid = ~inValid;
            inData  = 8'h7F;
            tick();
            checkOutput({name, " stall data"},  outDataRelu,  eRelu);
            checkOutput({name, " stall ready"}, inReadyRelu,  32'd0);
            checkOutput({name, " stall valid"}, outValidRelu, 32'd1);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        tick();
        checkOutput({name, " valid drop"}, outValidRelu, 32'd0);
        checkOutput({name, " ready back"}, inReadyRelu,  32'd1);
    endtask

    initial begin
        logic [N-1:0] mixed[LEN];
        int rnd;

        rst_n    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        checkOutput("reset out_valid", outValidRelu, 32'd0);
        checkOutput("reset out_data",  outDataLin,   32'd0);
        checkOutput("reset out_sat",   outSatLin,    32'd0);
        checkOutput("reset in_ready",  inReadyRelu,  32'd1);

        // +0.5 x 9 = +4.5
        sendWindow(8'h08, 0);
        awaitResult("half", 8'h48, 8'h48, 1'b0, 0);

        // +1.0 x 9 overflows; -1.0 x 9 underflows
        sendWindow(8'h10, 0);
        awaitResult("posSat", 8'h7F, 8'h7F, 1'b1, 0);
        sendWindow(8'hF0, 0);
        awaitResult("negSat", 8'h00, 8'h80, 1'b1, 0);

        // 4*0x30 - 4*0x10 + 5 = 0x85 saturates; with 0x20 it is 0x45
        for (int i = 0; i < 8; i++) mixed[i] = (i % 2 == 0) ? 8'h30 : 8'hF0;
        mixed[8] = 8'h05;
        for (int i = 0; i < LEN; i++) applyStimulus(mixed[i], 0);
        awaitResult("mixHi", 8'h7F, 8'h7F, 1'b1, 0);
        for (int i = 0; i < 8; i += 2) mixed[i] = 8'h20;
        for (int i = 0; i < LEN; i++) applyStimulus(mixed[i], 0);
        awaitResult("mixLo", 8'h45, 8'h45, 1'b0, 0);

        // Backpressure for 5 cycles, then a fresh window
        outReady = 1'b0;
        sendWindow(8'h04, 0);
        awaitResult("stall", 8'h24, 8'h24, 1'b0, 5);
        sendWindow(8'h01, 0);
        awaitResult("afterStall", 8'h09, 8'h09, 1'b0, 0);

        // Reset mid-window, with a term presented on the reset edge
        pulseCount = 0;
        for (int i = 0; i < 4; i++) applyStimulus(8'h20, 0);
        rst_n   = 1'b0;
        inValid = 1'b1;
        inData  = 8'h20;
        tick();
        rst_n   = 1'b1;
        inValid = 1'b0;
        checkOutput("midReset in_ready", inReadyRelu, 32'd1);
        sendWindow(8'h01, 0);
        awaitResult("midReset", 8'h09, 8'h09, 1'b0, 0);
        repeat (3) tick();
        checkOutput("midReset pulses", pulseCount, 32'd1);

        // Gapped input
        sendWindow(8'h02, 3);
        awaitResult("gapped", 8'h12, 8'h12, 1'b0, 0);

        // Random traffic, stalls and occasional resets against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            inValid = $urandom_range(0, 2) != 0;
            rnd     = $urandom_range(0, 3);
            case (rnd)
                0:       inData = N'($urandom);
                1:       inData = 8'h7F;
                2:       inData = 8'h80;
                default: inData = N'($urandom_range(0, 31) - 16);
            endcase
            outReady = $urandom_range(0, 3) != 0;
            tick();
        end
        rst_n    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        repeat (5) tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
